pipeline_stall_ctrl: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 29 ++
 rtl/pipe_perf_counter.sv | 25 ++
 rtl/pipeline_stall_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, pipeline controller state and the
// per-cycle control bundle driven by pipeline_stall_ctrl.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DWAIT  = 2'b01,
    HALTED = 2'b10
  } pipe_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
    logic dmem_ren;
    logic dmem_wen;
  } pipe_ctl_t;

  localparam word_t PERF_CNT_MAX = '1;

endpackage

// File: rtl/pipe_perf_counter.sv
// Saturating 32-bit event counter; counts cycles with inc=1, sticks at
// all-ones, async active-low clear.
module pipe_perf_counter
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  inc,
  output word_t count
);

  word_t r_count;

  // Count qualified events, holding at the maximum value
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_count <= '0;
    end else if (inc && (r_count != PERF_CNT_MAX)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller for the 5-stage datapath.
// Turns hazard, memory handshake, branch and halt inputs into per-latch
// enables/flushes, PC enable and data-memory requests, combinationally
// from the registered state. Optional performance counters are built
// only when PIPE_PERF_EN is defined; otherwise stall_cnt/flush_cnt read 0.
module pipeline_stall_ctrl
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ihit,
  input  logic  dhit,
  input  logic  hazard_detected,
  input  logic  ex_mem_memread,
  input  logic  ex_mem_memwrite,
  input  logic  branch_taken,
  input  logic  mem_wb_halt,
  output logic  pc_en,
  output logic  ifid_en,
  output logic  idex_en,
  output logic  exmem_en,
  output logic  memwb_en,
  output logic  ifid_flush,
  output logic  idex_flush,
  output logic  exmem_flush,
  output logic  memwb_flush,
  output logic  dmem_ren,
  output logic  dmem_wen,
  output logic  halted,
  output word_t stall_cnt,
  output word_t flush_cnt
);

  pipe_state_t r_state;
  pipe_state_t w_state_nxt;
  pipe_ctl_t   w_ctl;
  logic        w_mem_pend;
  logic        w_skip_halt;

  assign w_mem_pend  = (ex_mem_memread | ex_mem_memwrite) & ~dhit;
  // On the dhit cycle that ends a data wait, evaluation resumes at the
  // branch rule, so a halt request is not considered in that cycle.
  assign w_skip_halt = (r_state == DWAIT) & dhit;

  // Controller state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Prioritised stall/flush decision and next-state selection
  always_comb begin
    w_ctl       = '0;
    w_state_nxt = r_state;
    if (!nRST) begin
      w_ctl.ifid_flush  = 1'b1;
      w_ctl.idex_flush  = 1'b1;
      w_ctl.exmem_flush = 1'b1;
      w_ctl.memwb_flush = 1'b1;
      w_state_nxt       = RUN;
    end else if (r_state == HALTED) begin
      w_state_nxt = HALTED;
    end else begin
      w_ctl.dmem_ren = ex_mem_memread;
      w_ctl.dmem_wen = ex_mem_memwrite;
      if (mem_wb_halt && !w_skip_halt) begin
        w_state_nxt = HALTED;
      end else if (w_mem_pend) begin
        w_ctl.memwb_en    = 1'b1;
        w_ctl.memwb_flush = 1'b1;
        w_state_nxt       = DWAIT;
      end else begin
        w_state_nxt    = RUN;
        w_ctl.pc_en    = 1'b1;
        w_ctl.ifid_en  = 1'b1;
        w_ctl.idex_en  = 1'b1;
        w_ctl.exmem_en = 1'b1;
        w_ctl.memwb_en = 1'b1;
        if (branch_taken) begin
          w_ctl.ifid_flush = 1'b1;
          w_ctl.idex_flush = 1'b1;
        end else if (hazard_detected) begin
          w_ctl.pc_en      = 1'b0;
          w_ctl.ifid_en    = 1'b0;
          w_ctl.idex_flush = 1'b1;
        end else if (!ihit) begin
          w_ctl.pc_en      = 1'b0;
          w_ctl.ifid_flush = 1'b1;
        end
      end
    end
  end

  assign pc_en       = w_ctl.pc_en;
  assign ifid_en     = w_ctl.ifid_en;
  assign idex_en     = w_ctl.idex_en;
  assign exmem_en    = w_ctl.exmem_en;
  assign memwb_en    = w_ctl.memwb_en;
  assign ifid_flush  = w_ctl.ifid_flush;
  assign idex_flush  = w_ctl.idex_flush;
  assign exmem_flush = w_ctl.exmem_flush;
  assign memwb_flush = w_ctl.memwb_flush;
  assign dmem_ren    = w_ctl.dmem_ren;
  assign dmem_wen    = w_ctl.dmem_wen;
  assign halted      = (r_state == HALTED);

`ifdef PIPE_PERF_EN
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_stall_inc = nRST & (r_state != HALTED) & ~w_ctl.pc_en;
  assign w_flush_inc = nRST & (r_state != HALTED) & ~(mem_wb_halt & ~w_skip_halt)
                     & ~w_mem_pend & branch_taken;

  pipe_perf_counter u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  pipe_perf_counter u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (w_flush_inc),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios plus
// randomized cycles compared against a rule-level reference model.
module tb_pipeline_stall_ctrl;

  logic        CLK;
  logic        nRST;
  logic        ihit, dhit, hazard_detected;
  logic        ex_mem_memread, ex_mem_memwrite, branch_taken, mem_wb_halt;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic        dmem_ren, dmem_wen, halted;
  logic [31:0] stall_cnt, flush_cnt;

  int unsigned n_assert;
  int unsigned n_fail;

  // Reference model state
  bit          m_halted;
  bit          m_waiting;
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  pipeline_stall_ctrl dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .ihit            (ihit),
    .dhit            (dhit),
    .hazard_detected (hazard_detected),
    .ex_mem_memread  (ex_mem_memread),
    .ex_mem_memwrite (ex_mem_memwrite),
    .branch_taken    (branch_taken),
    .mem_wb_halt     (mem_wb_halt),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .memwb_en        (memwb_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .exmem_flush     (exmem_flush),
    .memwb_flush     (memwb_flush),
    .dmem_ren        (dmem_ren),
    .dmem_wen        (dmem_wen),
    .halted          (halted),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [10:0] obs_ctl();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_flush, idex_flush, exmem_flush, memwb_flush,
            dmem_ren, dmem_wen};
  endfunction

  // Which priority rule wins this cycle (0 = halted, nothing applies)
  function automatic int winning_rule();
    if (m_halted) return 0;
    if (mem_wb_halt && !(m_waiting && dhit)) return 1;
    if ((ex_mem_memread || ex_mem_memwrite) && !dhit) return 2;
    if (branch_taken) return 3;
    if (hazard_detected) return 4;
    if (!ihit) return 5;
    return 6;
  endfunction

  // Expected {pc,ifid,idex,exmem,memwb en ; ifid,idex,exmem,memwb flush ; ren,wen}
  function automatic logic [10:0] exp_ctl(input int rule);
    logic [1:0] req;
    req = {ex_mem_memread, ex_mem_memwrite};
    case (rule)
      1:       return {5'b00000, 4'b0000, req};
      2:       return {5'b00001, 4'b0001, req};
      3:       return {5'b11111, 4'b1100, req};
      4:       return {5'b00111, 4'b0100, req};
      5:       return {5'b01111, 4'b1000, req};
      6:       return {5'b11111, 4'b0000, req};
      default: return 11'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_counters(input string tag);
`ifdef PIPE_PERF_EN
    chk({tag, "_stall_cnt"}, stall_cnt, m_stall);
    chk({tag, "_flush_cnt"}, flush_cnt, m_flush);
`else
    chk({tag, "_stall_cnt"}, stall_cnt, 32'd0);
    chk({tag, "_flush_cnt"}, flush_cnt, 32'd0);
`endif
  endtask

  task automatic model_reset();
    m_halted  = 1'b0;
    m_waiting = 1'b0;
    m_stall   = '0;
    m_flush   = '0;
  endtask

  // Called at a negative edge: drive inputs, check, advance one clock,
  // update the model, return at the next negative edge.
  task automatic step(input string tag, input logic ih, input logic dh, input logic hz,
                      input logic rd, input logic wr, input logic br, input logic hl);
    int rule;
    logic [10:0] e;
    ihit = ih; dhit = dh; hazard_detected = hz;
    ex_mem_memread = rd; ex_mem_memwrite = wr;
    branch_taken = br; mem_wb_halt = hl;
    #1;
    rule = winning_rule();
    e    = exp_ctl(rule);
    chk({tag, "_ctl"}, {21'd0, obs_ctl()}, {21'd0, e});
    chk({tag, "_halted"}, {31'd0, halted}, {31'd0, m_halted});
    chk_counters(tag);
    @(posedge CLK);
    if (!m_halted) begin
      if (e[10] == 1'b0 && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (rule == 3 && m_flush != 32'hFFFF_FFFF) m_flush++;
      m_waiting = (rule == 2);
      if (rule == 1) m_halted = 1'b1;
    end
    @(negedge CLK);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ctl"}, {21'd0, obs_ctl()}, {21'd0, 11'b00000_1111_00});
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
    chk({tag, "_stall_cnt"}, stall_cnt, 32'd0);
    chk({tag, "_flush_cnt"}, flush_cnt, 32'd0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    model_reset();
    nRST = 1'b0;
    ihit = 1'b0; dhit = 1'b0; hazard_detected = 1'b0;
    ex_mem_memread = 1'b0; ex_mem_memwrite = 1'b0;
    branch_taken = 1'b0; mem_wb_halt = 1'b0;

    // Reset values while nRST is low
    #2;
    chk_reset_values("reset");
    @(negedge CLK);
    nRST = 1'b1;

    // Normal flow
    for (int i = 0; i < 3; i++) step("normal", 1, 0, 0, 0, 0, 0, 0);

    // Load waiting on data memory, then completing
    for (int i = 0; i < 3; i++) step("dwait", 1, 0, 0, 1, 0, 0, 0);
    step("dwait_done", 1, 1, 0, 1, 0, 0, 0);
    step("after_dwait", 1, 0, 0, 0, 0, 0, 0);

    // Store waiting, completing together with a taken branch
    step("st_wait", 1, 0, 0, 0, 1, 0, 0);
    step("st_done_br", 1, 1, 0, 0, 1, 1, 0);

    // Load-use hazard then normal
    step("hazard", 1, 0, 1, 0, 0, 0, 0);
    step("post_hazard", 1, 0, 0, 0, 0, 0, 0);

    // Branch beats hazard; fetch miss
    step("br_haz", 1, 0, 1, 0, 0, 1, 0);
    step("imiss", 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic without halt
    for (int i = 0; i < 400; i++) begin
      logic rd, wr;
      rd = ($urandom_range(0, 2) == 0);
      wr = !rd && ($urandom_range(0, 3) == 0);
      step("rand", ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
           ($urandom_range(0, 3) == 0), rd, wr, ($urandom_range(0, 4) == 0), 0);
    end

    // Asynchronous reset in the middle of a data wait
    step("pre_rst_wait", 1, 0, 0, 1, 0, 0, 0);
    step("pre_rst_wait2", 1, 0, 0, 1, 0, 0, 0);
    #2;
    nRST = 1'b0;
    #1;
    chk_reset_values("async_rst");
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    step("post_rst_idle", 1, 0, 0, 0, 0, 0, 0);
    step("post_rst_load", 1, 1, 0, 1, 0, 0, 0);

    // Halt: sticky until reset, requests suppressed
    step("halt_req", 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("halted", 1, 0, 1, 1, 0, 1, 0);
    #2;
    nRST = 1'b0;
    #1;
    chk_reset_values("halt_rst");
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    step("after_halt_rst", 1, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
